// File: rtl/clock_pkg.sv
// Shared definitions for the clock display path: conversion state
// encoding, the blank segment pattern and the 7-segment digit decoder.
package clock_pkg;

    // Conversion engine states; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        UPDATE = 2'b10
    } conv_state_e;

    // All segments off on a common-anode display (segments are active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Decimal digit to active-low segments {g,f,e,d,c,b,a}.
    // Codes 10..15 never reach here from the converter; they show blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter for one 6-bit field (0..63) into
// a tens and a units BCD digit. One bit is processed per clock.
//
// Handshake: start is sampled only while busy is low (state IDLE); the
// cycle start is seen high in IDLE the operand is taken and busy rises.
// done is high for exactly one cycle (state UPDATE), during which tens and
// units hold the final result; busy stays high through that cycle and
// drops on the following edge.
module bin2bcd_seq
    import clock_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  bin_in,
    output logic        busy,
    output logic        done,
    output logic [3:0]  tens,
    output logic [3:0]  units,
    output conv_state_e state_dbg
);

    conv_state_e state;
    conv_state_e state_nxt;
    logic [2:0]  cnt;
    // Shift register layout: {tens[3:0], units[3:0], binary[5:0]}.
    logic [13:0] sh;
    logic [13:0] sh_adj;

    // Add 3 to any BCD nibble that is 5 or more ahead of the shift.
    always_comb begin
        sh_adj = sh;
        if (sh[9:6] >= 4'd5) begin
            sh_adj[9:6] = sh[9:6] + 4'd3;
        end
        if (sh[13:10] >= 4'd5) begin
            sh_adj[13:10] = sh[13:10] + 4'd3;
        end
    end

    // Next-state logic: six shift steps, then a single result cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == 3'd5) state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture and the per-cycle correct-then-shift step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh  <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh  <= {8'd0, bin_in};
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sh  <= sh_adj << 1;
                    cnt <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == UPDATE);
    assign tens      = sh[13:10];
    assign units     = sh[9:6];
    assign state_dbg = state;

endmodule

// File: rtl/display_scan_driver.sv
// Converts the hours/minutes pair to BCD and time-multiplexes the four
// digits onto a common-anode 7-segment display. Owns seg/an/dp.
module display_scan_driver
    import clock_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int PRESC_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] hours_fsm,
    input  logic [5:0] minutes_fsm,
    input  logic       alarm_sound,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       conv_busy
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

    // Change detector: first forces a conversion after reset even when
    // the inputs equal the cleared last_pair.
    logic        first;
    logic [11:0] last_pair;
    logic        start;

    // Both converters run in lockstep from one shared start.
    logic        h_busy, m_busy;
    logic        h_done, m_done;
    logic [3:0]  h_tens_c, h_units_c, m_tens_c, m_units_c;
    conv_state_e h_state_dbg, m_state_dbg;

    // Displayed digits, updated only when a conversion completes.
    logic [3:0] h_tens, h_units, m_tens, m_units;

    logic [PRESC_W-1:0] presc;
    logic [1:0]         idx;
    logic [3:0]         cur_digit;
    logic [6:0]         seg_nxt;

    assign start = (h_state_dbg == IDLE) && (m_state_dbg == IDLE) &&
                   (first || ({hours_fsm, minutes_fsm} != last_pair));

    bin2bcd_seq u_conv_hours (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin_in    (hours_fsm),
        .busy      (h_busy),
        .done      (h_done),
        .tens      (h_tens_c),
        .units     (h_units_c),
        .state_dbg (h_state_dbg)
    );

    bin2bcd_seq u_conv_minutes (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin_in    (minutes_fsm),
        .busy      (m_busy),
        .done      (m_done),
        .tens      (m_tens_c),
        .units     (m_units_c),
        .state_dbg (m_state_dbg)
    );

    assign conv_busy = h_busy | m_busy;

    // Remember the pair being converted so later changes can be detected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first     <= 1'b1;
            last_pair <= '0;
        end else if (start) begin
            first     <= 1'b0;
            last_pair <= {hours_fsm, minutes_fsm};
        end
    end

    // Load the display digits on the converters' result cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_tens  <= '0;
            h_units <= '0;
            m_tens  <= '0;
            m_units <= '0;
        end else if (h_done && m_done) begin
            h_tens  <= h_tens_c;
            h_units <= h_units_c;
            m_tens  <= m_tens_c;
            m_units <= m_units_c;
        end
    end

    // Prescaler sets the digit dwell; idx advances at its terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= idx + 2'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Select the digit for the current slot and blank a leading hours zero.
    always_comb begin
        cur_digit = m_units;
        case (idx)
            2'd0: cur_digit = m_units;
            2'd1: cur_digit = m_tens;
            2'd2: cur_digit = h_units;
            2'd3: cur_digit = h_tens;
            default: cur_digit = m_units;
        endcase
        seg_nxt = seg_decode(cur_digit);
        if ((idx == 2'd3) && (h_tens == 4'd0)) begin
            seg_nxt = SEG_BLANK;
        end
    end

    // Register seg, an and dp together so the anode and segments switch
    // on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_BLANK;
            an  <= 4'hF;
            dp  <= 1'b1;
        end else begin
            seg <= seg_nxt;
            an  <= ~(4'b0001 << idx);
            dp  <= !(alarm_sound || (idx == 2'd2));
        end
    end

endmodule
